fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. It accepts write requests, advances a binary write pointer that addresses the dual-port memory, and publishes a Gray-coded write pointer. That Gray pointer feeds the two-flop synchronizer into the read domain. It also consumes the read pointer after synchronization into the write domain, and from it produces `wfull`, an occupancy count, `almost_full` and a sticky overflow flag.

## Interface
- `Datawidth`, 8: FIFO data width. Unused internally; kept for uniform parameter lists across FIFO blocks.
- `Width`, 3: address bits. Pointers are `Width+1` bits. Legal values are `Width` ≥ 2.
- `Depth`, 8: FIFO depth. Must equal 2**`Width`.
- `AF_LEVEL`, 6: occupancy at or above which `almost_full` asserts. Range 1..`Depth`.

- `clk`  in  1  write-domain clock.
- `rst`  in  1  reset: one clock, synchronous, active-high.
- `w_en`  in  1  write request.
- `wq2_rptr`  in  `Width+1`  Gray read pointer, already synchronized into `clk` domain.
- `waddr`  out  `Width`  memory write address (registered).
- `wptr`  out  `Width+1`  Gray write pointer (registered). Goes to the read-domain synchronizer.
- `w_ok`  out  1  combinational, `w_en & ~wfull`. This is the memory write strobe.
- `wfull`  out  1  FIFO full (registered).
- `almost_full`  out  1  occupancy ≥ `AF_LEVEL` (registered).
- `wcount`  out  `Width+1`  occupancy as seen from the write domain, 0..`Depth` (registered).
- `overflow`  out  1  sticky: a write was attempted while full.

## Operation
- Internal binary pointer `wbin`, `Width+1` bits.
- `wbin_next` = `wbin + w_ok`, modulo 2**(`Width+1`).
- `wgray_next` = (`wbin_next` >> 1) ^ `wbin_next`.
- On each rising `clk` with `rst`=0:
  - `wbin` <= `wbin_next`
  - `wptr` <= `wgray_next`
- `waddr` = `wbin[Width-1:0]`.
- Full detection:
  - `wfull` <= (`wgray_next` == {~`wq2_rptr[Width:Width-1]`, `wq2_rptr[Width-2:0]`}).
  - Uses the next pointer, so `wfull` is valid in the cycle immediately after the filling write.
- Occupancy:
  - `rbin` is the Gray-to-binary conversion of `wq2_rptr`: an XOR prefix from the MSB down.
  - `wcount` <= `wbin_next - rbin`, modulo 2**(`Width+1`).
  - `almost_full` <= (`wbin_next - rbin` ≥ `AF_LEVEL`).
- Overflow: `overflow` <= `overflow | (w_en & wfull)`. It is cleared only by `rst`.
- Write while full: the write is dropped. Pointers, `waddr` and `wptr` hold and `w_ok`=0.
- Full-flag behaviour with a moving read pointer:
  - `wfull` is pessimistic. It deasserts no earlier than one `clk` after `wq2_rptr` advances.
  - Never optimistic: a read-side advance can only lower the count.
- Simultaneous write and read-pointer advance in the same cycle: both terms are used, and the net count is unchanged.
- Wrap-around: the MSB toggles every `Depth` writes. Gray `wptr` changes exactly one bit per accepted write, including the wrap from 2**(`Width+1`)−1 to 0.

## Timing
- Reset (`rst`=1 at a `clk` edge):
  - Registers after that edge: `wbin`=0, `wptr`=0, `waddr`=0, `wfull`=0, `almost_full`=0, `wcount`=0, `overflow`=0.
  - `w_ok` is forced to 0 while `rst`=1, so a write presented in a reset cycle is ignored.
- Reset mid-operation: all state returns to zero on the next edge, regardless of `w_en`. The read domain must be reset in the same window, because the pointers are not re-aligned by this block.
- Latency, accepted write to `wptr`/`waddr` update: one `clk`.
- Latency, accepted write to `wfull`/`wcount`/`almost_full` update: one `clk`.
- Latency, `wq2_rptr` change to flag/count update: one `clk`.
- Total read-to-`wfull`-release latency is 3 `clk` edges: two synchronizer stages plus this register.
- `wptr` is driven directly from a flop, with no combinational logic between the flop and the synchronizer input.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `w_en`=1.
  - `wptr`=0000, `waddr`=0, `wfull`=0, `wcount`=0, `overflow`=0.
  - No `w_ok` pulse during reset.
- **Fill:** `wq2_rptr`=0000, `w_en`=1 for 8 cycles.
  - `wptr` sequence: 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
  - `waddr` sequence: 1..7 then 0.
  - `almost_full`=1 after the 6th write. `wfull`=1 and `wcount`=8 after the 8th write.
- **Write when full:** hold `w_en`=1 for 3 more cycles.
  - `w_ok`=0 throughout; `wptr` holds at 1100.
  - `overflow`=1 and stays 1 after `w_en` drops.
- **Release:** set `wq2_rptr`=0001.
  - Next cycle: `wfull`=0, `wcount`=7.
  - One write then gives `wptr`=1101, `wfull`=1, `wcount`=8.
- **Wrap-around:** drive `wq2_rptr` to track `wptr` delayed 2 cycles; write 20 times.
  - `wptr` passes 1000 → 0000.
  - No false `wfull`, `wcount` ≤ 2, exactly one bit change per write.
- **Simultaneous events:** at `wcount`=5, write and advance `wq2_rptr` by one in the same cycle.
  - `wcount` stays 5; `almost_full` stays 0.
  - Then `rst` mid-stream with `w_en`=1: all outputs are 0 on the next edge.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// Publishes a registered Gray write pointer and derives full, almost-full, occupancy and overflow.
module fifo_wptr_full #(
    parameter int Datawidth = 8,
    parameter int Width     = 3,
    parameter int Depth     = 8,
    parameter int AF_LEVEL  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [Width:0]   wq2_rptr,
    output logic [Width-1:0] waddr,
    output logic [Width:0]   wptr,
    output logic             w_ok,
    output logic             wfull,
    output logic             almost_full,
    output logic [Width:0]   wcount,
    output logic             overflow
);

    if (Width < 2 || Depth != (1 << Width) || AF_LEVEL < 1 || AF_LEVEL > Depth || Datawidth < 1) begin : g_param_check
        $error("fifo_wptr_full: illegal parameter combination");
    end

    localparam logic [Width:0] AF_THR = (Width + 1)'(AF_LEVEL);

    function automatic logic [Width:0] gray2bin(input logic [Width:0] gray);
        logic [Width:0] bin;
        bin[Width] = gray[Width];
        for (int i = Width - 1; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

    logic [Width:0] wbin_q, wbin_d;
    logic [Width:0] wptr_q, wgray_d;
    logic [Width:0] wcount_q, wcount_d;
    logic [Width:0] rbin_s;
    logic           wfull_q, wfull_d;
    logic           af_q, af_d;
    logic           ovf_q, ovf_d;
    logic           w_ok_s;

    // Next-state: pointer advance, full compare against the synchronized read pointer, occupancy.
    always_comb begin
        w_ok_s   = w_en & ~wfull_q & ~rst;
        wbin_d   = wbin_q + {{Width{1'b0}}, w_ok_s};
        wgray_d  = (wbin_d >> 1) ^ wbin_d;
        rbin_s   = gray2bin(wq2_rptr);
        wcount_d = wbin_d - rbin_s;
        // Full when the next pointer equals the read pointer with its two MSBs inverted.
        wfull_d  = (wgray_d == {~wq2_rptr[Width:Width-1], wq2_rptr[Width-2:0]});
        af_d     = (wcount_d >= AF_THR);
        ovf_d    = ovf_q | (w_en & wfull_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wgray_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign waddr       = wbin_q[Width-1:0];
    assign wptr        = wptr_q;
    assign w_ok        = w_ok_s;
    assign wfull       = wfull_q;
    assign almost_full = af_q;
    assign wcount      = wcount_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed scenarios plus random writes/reads against an occupancy model.
module tb_fifo_wptr_full;
    localparam int W  = 3;
    localparam int D  = 8;
    localparam int AF = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         w_en;
    logic [W:0]   wq2_rptr;
    logic [W-1:0] waddr;
    logic [W:0]   wptr;
    logic         w_ok;
    logic         wfull;
    logic         almost_full;
    logic [W:0]   wcount;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: total accepted writes and read position (mod 16), flags from occupancy.
    int   m_wr  = 0;
    int   m_rd  = 0;
    int   m_cnt = 0;
    logic m_full = 1'b0;
    logic m_af   = 1'b0;
    logic m_ovf  = 1'b0;
    logic m_ok   = 1'b0;

    fifo_wptr_full #(.Datawidth(8), .Width(W), .Depth(D), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .wq2_rptr(wq2_rptr),
        .waddr(waddr), .wptr(wptr), .w_ok(w_ok), .wfull(wfull),
        .almost_full(almost_full), .wcount(wcount), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] to_gray(input int b);
        logic [W:0] v;
        v = b[W:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [13:0] exp_state();
        logic [W-1:0] a;
        logic [W:0]   c;
        a = m_wr[W-1:0];
        c = m_cnt[W:0];
        return {to_gray(m_wr), a, m_full, m_af, c, m_ovf};
    endfunction

    task automatic apply(input logic we, input logic r, input int rd);
        w_en     = we;
        rst      = r;
        m_rd     = rd % 16;
        wq2_rptr = to_gray(m_rd);
        m_ok     = we && !m_full && !r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            m_wr = 0; m_cnt = 0; m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        end else begin
            m_ovf = m_ovf | (w_en & m_full);
            if (m_ok) m_wr = (m_wr + 1) % 16;
            m_cnt  = (((m_wr - m_rd) % 16) + 16) % 16;
            m_full = (m_cnt == D);
            m_af   = (m_cnt >= AF);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 0);
            #1;
            n_tests++;
            if (w_ok !== 1'b0) begin n_fail++; $display("FAIL reset_w_ok: got %b expected 0", w_ok); end
            tick();
        end
        n_tests++;
        if ({wptr, waddr, wfull, almost_full, wcount, overflow} !== exp_state())
            begin n_fail++; $display("FAIL reset_state: got %h expected %h", {wptr, waddr, wfull, almost_full, wcount, overflow}, exp_state()); end
    endtask

    task automatic test_fill();
        int exp_g[8] = '{1, 3, 2, 6, 7, 5, 4, 12};
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b0, 0);
            #1;
            n_tests++;
            if (w_ok !== m_ok) begin n_fail++; $display("FAIL fill_w_ok[%0d]: got %b expected %b", i, w_ok, m_ok); end
            tick();
            n_tests++;
            if (wptr !== exp_g[i][W:0] || waddr !== 3'((i + 1) % 8))
                begin n_fail++; $display("FAIL fill_ptr[%0d]: got wptr=%b waddr=%0d expected wptr=%b waddr=%0d", i, wptr, waddr, exp_g[i][W:0], (i + 1) % 8); end
            n_tests++;
            if ({wptr, waddr, wfull, almost_full, wcount, overflow} !== exp_state())
                begin n_fail++; $display("FAIL fill_state[%0d]: got %h expected %h", i, {wptr, waddr, wfull, almost_full, wcount, overflow}, exp_state()); end
            if (i == 5) begin
                n_tests++;
                if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af6: got %b expected 1", almost_full); end
            end
        end
        n_tests++;
        if ({wfull, wcount} !== {1'b1, 4'd8}) begin n_fail++; $display("FAIL fill_full: got wfull=%b wcount=%0d expected 1/8", wfull, wcount); end
    endtask

    task automatic test_write_full();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 0);
            #1;
            n_tests++;
            if (w_ok !== 1'b0) begin n_fail++; $display("FAIL wfull_w_ok[%0d]: got %b expected 0", i, w_ok); end
            tick();
            n_tests++;
            if ({wptr, overflow} !== {4'b1100, 1'b1}) begin n_fail++; $display("FAIL wfull_hold[%0d]: got wptr=%b ovf=%b expected 1100/1", i, wptr, overflow); end
        end
        apply(1'b0, 1'b0, 0);
        tick();
        n_tests++;
        if ({wptr, waddr, wfull, almost_full, wcount, overflow} !== exp_state() || overflow !== 1'b1)
            begin n_fail++; $display("FAIL ovf_sticky: got %h expected %h", {wptr, waddr, wfull, almost_full, wcount, overflow}, exp_state()); end
    endtask

    task automatic test_release();
        apply(1'b0, 1'b0, 1);
        tick();
        n_tests++;
        if ({wfull, wcount} !== {1'b0, 4'd7}) begin n_fail++; $display("FAIL release: got wfull=%b wcount=%0d expected 0/7", wfull, wcount); end
        apply(1'b1, 1'b0, 1);
        #1;
        n_tests++;
        if (w_ok !== 1'b1) begin n_fail++; $display("FAIL release_w_ok: got %b expected 1", w_ok); end
        tick();
        n_tests++;
        if ({wptr, wfull, wcount} !== {4'b1101, 1'b1, 4'd8})
            begin n_fail++; $display("FAIL refill: got wptr=%b wfull=%b wcount=%0d expected 1101/1/8", wptr, wfull, wcount); end
    endtask

    task automatic test_wrap();
        int         h1;
        int         h2;
        logic [W:0] prev;
        bit         saw_wrap = 1'b0;
        apply(1'b0, 1'b0, m_wr);
        tick();
        h1 = m_wr;
        h2 = m_wr;
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b0, h2);
            #1;
            n_tests++;
            if (w_ok !== 1'b1) begin n_fail++; $display("FAIL wrap_w_ok[%0d]: got %b expected 1", i, w_ok); end
            prev = wptr;
            tick();
            h2 = h1;
            h1 = m_wr;
            n_tests++;
            if ($countones(wptr ^ prev) != 1 || wfull !== 1'b0 || wcount > 4'd2)
                begin n_fail++; $display("FAIL wrap_step[%0d]: got prev=%b wptr=%b wfull=%b wcount=%0d", i, prev, wptr, wfull, wcount); end
            n_tests++;
            if ({wptr, waddr, wfull, almost_full, wcount, overflow} !== exp_state())
                begin n_fail++; $display("FAIL wrap_state[%0d]: got %h expected %h", i, {wptr, waddr, wfull, almost_full, wcount, overflow}, exp_state()); end
            if (prev == 4'b1000 && wptr == 4'b0000) saw_wrap = 1'b1;
        end
        n_tests++;
        if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_seen: got %b expected 1", saw_wrap); end
    endtask

    task automatic test_random();
        logic we;
        logic r;
        int   rd;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 59) == 0);
            rd = m_rd;
            if (r) rd = 0;
            else if (m_cnt > 0 && $urandom_range(0, 2) == 0) rd = m_rd + 1;
            apply(we, r, rd);
            #1;
            n_tests++;
            if (w_ok !== m_ok) begin n_fail++; $display("FAIL rand_w_ok[%0d]: got %b expected %b", i, w_ok, m_ok); end
            tick();
            n_tests++;
            if ({wptr, waddr, wfull, almost_full, wcount, overflow} !== exp_state())
                begin n_fail++; $display("FAIL rand_state[%0d]: got %h expected %h", i, {wptr, waddr, wfull, almost_full, wcount, overflow}, exp_state()); end
        end
    endtask

    task automatic test_simultaneous();
        apply(1'b0, 1'b1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 0);
            tick();
        end
        n_tests++;
        if (wcount !== 4'd5) begin n_fail++; $display("FAIL sim_pre: got wcount=%0d expected 5", wcount); end
        apply(1'b1, 1'b0, 1);
        tick();
        n_tests++;
        if ({wcount, almost_full} !== {4'd5, 1'b0} || {wptr, waddr, wfull, almost_full, wcount, overflow} !== exp_state())
            begin n_fail++; $display("FAIL sim_net: got wcount=%0d af=%b expected 5/0", wcount, almost_full); end
        apply(1'b1, 1'b1, 0);
        #1;
        n_tests++;
        if (w_ok !== 1'b0) begin n_fail++; $display("FAIL midrst_w_ok: got %b expected 0", w_ok); end
        tick();
        n_tests++;
        if ({wptr, waddr, wfull, almost_full, wcount, overflow} !== exp_state() || wptr !== 4'b0000)
            begin n_fail++; $display("FAIL midrst_state: got %h expected %h", {wptr, waddr, wfull, almost_full, wcount, overflow}, exp_state()); end
    endtask

    initial begin
        rst      = 1'b1;
        w_en     = 1'b0;
        wq2_rptr = '0;
        #2;
        test_reset();
        test_fill();
        test_write_full();
        test_release();
        test_wrap();
        test_random();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
